// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: FSM encoding, error codes and the default marker.
package loader_pkg;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StLen   = 3'd1,
    StData  = 3'd2,
    StCsum  = 3'd3,
    StDone  = 3'd4,
    StError = 3'd5
  } state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CSUM    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/byte_timeout.sv
// Idle-cycle counter; pulses expired on the cycle the TIMEOUT_CYCLES-th idle edge would land.
module byte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic expired
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr || !en) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // An accepted byte in the same cycle wins over expiry.
  assign expired = en && !clr && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/prog_loader.sv
// Framed byte-stream loader: writes the program into instruction memory and holds the core
// in reset until a frame with a good checksum has been received.
module prog_loader
  import loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter logic [7:0]  SYNC_BYTE      = DEFAULT_SYNC_BYTE,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code,
  output logic [7:0]            bytes_loaded
);

  state_e state_q, state_d;

  logic [7:0]            len_q, len_d;
  logic [7:0]            sum_q, sum_d;
  logic [7:0]            idx_q, idx_d;
  logic [7:0]            bytes_q, bytes_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
  logic [1:0]            err_q, err_d;
  logic                  hold_q, done_q, error_q;

  logic accept, is_sync, in_frame, timeout;

  assign in_ready = 1'b1;
  assign accept   = in_valid && in_ready;
  assign is_sync  = (in_data == SYNC_BYTE);
  assign in_frame = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);

  byte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (reset),
    .en     (in_frame),
    .clr    (accept),
    .expired(timeout)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      bytes_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
      err_q      <= ERR_NONE;
      hold_q     <= 1'b1;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      bytes_q    <= bytes_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
      err_q      <= err_d;
      hold_q     <= (state_d != StDone);
      done_q     <= (state_d == StDone);
      error_q    <= (state_d == StError);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone, StError: begin
        if (accept && is_sync) state_d = StLen;
      end
      StLen: begin
        if (accept)       state_d = (in_data == 8'd0) ? StCsum : StData;
        else if (timeout) state_d = StError;
      end
      StData: begin
        if (accept) begin
          if (idx_q == len_q - 8'd1) state_d = StCsum;
        end else if (timeout) begin
          state_d = StError;
        end
      end
      StCsum: begin
        if (accept)       state_d = (in_data == sum_q) ? StDone : StError;
        else if (timeout) state_d = StError;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    len_d      = len_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    bytes_d    = bytes_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_data_d = mem_data_q;
    err_d      = err_q;

    if (accept && state_q == StLen) begin
      len_d   = in_data;
      sum_d   = in_data;
      idx_d   = '0;
      bytes_d = '0;
    end

    if (accept && state_q == StData) begin
      sum_d      = sum_q + in_data;
      idx_d      = idx_q + 8'd1;
      bytes_d    = bytes_q + 8'd1;
      mem_we_d   = 1'b1;
      mem_addr_d = ADDR_WIDTH'(idx_q);
      mem_data_d = DATA_WIDTH'(in_data);
    end

    if (state_d == StError && state_q != StError) begin
      err_d = (state_q == StCsum && accept) ? ERR_CSUM : ERR_TIMEOUT;
    end else if (state_d == StLen) begin
      err_d = ERR_NONE;
    end
  end

  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_data     = mem_data_q;
  assign cpu_hold     = hold_q;
  assign load_done    = done_q;
  assign load_error   = error_q;
  assign err_code     = err_q;
  assign bytes_loaded = bytes_q;

endmodule
